// File: rtl/input_buffer_sequencer_pkg.sv
// Shared parameters for the input-buffer sequencer: network modes, array geometry
// and the sequencer FSM state encoding.
package input_buffer_sequencer_pkg;

    localparam int N_DIM_ARRAY           = 8;
    localparam int MAXIMUM_DILATION_BITS = 4;

    localparam logic [2:0] MODE_CNN = 3'd0;
    localparam logic [2:0] MODE_FC  = 3'd1;
    localparam logic [2:0] MODE_EWS = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_TAP       = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/input_buffer_sequencer.sv
// Sequences clear / parallel-load / serial-shift strobes of the input buffer over a CNN sweep.
// Optional build macro INPUT_BUFFER_SEQ_STRIDE_EN adds the strided double-load path.
module input_buffer_sequencer #(
    parameter int N_DIM_ARRAY           = input_buffer_sequencer_pkg::N_DIM_ARRAY,
    parameter int MAXIMUM_DILATION_BITS = input_buffer_sequencer_pkg::MAXIMUM_DILATION_BITS,
    parameter int KX_BITS               = 4,
    parameter int TILE_BITS             = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2:0]                       mode,
    input  logic [KX_BITS-1:0]               cfg_kx,
    input  logic [MAXIMUM_DILATION_BITS-1:0] cfg_shift,
    input  logic [TILE_BITS-1:0]             cfg_tiles,
    input  logic                             mem_valid,
    input  logic                             array_ready,
`ifdef INPUT_BUFFER_SEQ_STRIDE_EN
    input  logic                             cfg_stride,
    output logic                             enable_strided_conv,
    output logic [1:0]                       cr_fifo,
`endif
    output logic                             clear,
    output logic                             loading_in_parallel,
    output logic                             enable,
    output logic [MAXIMUM_DILATION_BITS-1:0] shift_input_buffer,
    output logic                             mac_valid,
    output logic                             busy,
    output logic                             done
);
    import input_buffer_sequencer_pkg::*;

    localparam logic [MAXIMUM_DILATION_BITS-1:0] MAX_SHIFT = MAXIMUM_DILATION_BITS'(N_DIM_ARRAY);

    seq_state_t state, state_next;

    logic [KX_BITS-1:0]               kx_q, tap_cnt;
    logic [TILE_BITS-1:0]             tiles_q, tile_cnt;
    logic [MAXIMUM_DILATION_BITS-1:0] shift_q, shift_eff;
    logic                             accept, tap_go, last_tap, last_tile, load_more;

    assign accept    = (state == ST_IDLE) && start && (mode == MODE_CNN);
    assign tap_go    = (state == ST_TAP) && array_ready && mem_valid;
    assign last_tap  = (tap_cnt == kx_q - KX_BITS'(1));
    assign last_tile = (tile_cnt == tiles_q - TILE_BITS'(1));

    // Zero shift would stall the window; out-of-range values are clamped to the array width.
    always_comb begin
        shift_eff = cfg_shift;
        if (cfg_shift == '0)
            shift_eff = MAXIMUM_DILATION_BITS'(1);
        else if (cfg_shift > MAX_SHIFT)
            shift_eff = MAX_SHIFT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kx_q     <= '0;
            tiles_q  <= '0;
            shift_q  <= '0;
            tap_cnt  <= '0;
            tile_cnt <= '0;
        end else if (accept) begin
            kx_q     <= (cfg_kx == '0) ? KX_BITS'(1) : cfg_kx;
            tiles_q  <= (cfg_tiles == '0) ? TILE_BITS'(1) : cfg_tiles;
            shift_q  <= shift_eff;
            tap_cnt  <= '0;
            tile_cnt <= '0;
        end else if (tap_go) begin
            if (last_tap) begin
                tap_cnt  <= '0;
                tile_cnt <= tile_cnt + TILE_BITS'(1);
            end else begin
                tap_cnt  <= tap_cnt + KX_BITS'(1);
            end
        end
    end

`ifdef INPUT_BUFFER_SEQ_STRIDE_EN
    logic stride_q, load_phase, tap_par;

    // Strided tiles need a second parallel load; load_phase selects which half is written.
    assign load_more = stride_q & ~load_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q   <= 1'b0;
            load_phase <= 1'b0;
            tap_par    <= 1'b0;
        end else begin
            if (accept)
                stride_q <= cfg_stride;
            if (state == ST_LOAD && mem_valid && stride_q)
                load_phase <= ~load_phase;
            if (tap_go && !last_tap)
                tap_par <= ~tap_par;
            else if (state != ST_TAP)
                tap_par <= 1'b0;
        end
    end

    assign enable_strided_conv = stride_q & busy;
    assign cr_fifo = {stride_q & (state == ST_TAP) & tap_par,
                      stride_q & loading_in_parallel & load_phase};
`else
    assign load_more = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start) state_next = (mode == MODE_CNN) ? ST_CLEAR : ST_DONE;
            ST_CLEAR:     state_next = ST_LOAD;
            ST_LOAD:      if (mem_valid && !load_more) state_next = ST_LOAD_WAIT;
            ST_LOAD_WAIT: state_next = ST_TAP;
            ST_TAP:       if (tap_go && last_tap) state_next = last_tile ? ST_DONE : ST_LOAD;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clear               = 1'b0;
        loading_in_parallel = 1'b0;
        enable              = 1'b0;
        shift_input_buffer  = '0;
        mac_valid           = 1'b0;
        done                = 1'b0;
        busy                = (state != ST_IDLE);
        case (state)
            ST_CLEAR: clear = 1'b1;
            ST_LOAD:  loading_in_parallel = mem_valid;
            ST_TAP: begin
                mac_valid = 1'b1;
                if (tap_go && !last_tap) begin
                    enable             = 1'b1;
                    shift_input_buffer = shift_q;
                end
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: doc/input_buffer_sequencer.md
INPUT_BUFFER_SEQUENCER -- requirements
Module: input_buffer_sequencer

Interface
REQ-001 Parameter N_DIM_ARRAY, default 8: array width (activations per parallel load).
REQ-002 Parameter MAXIMUM_DILATION_BITS, default 4: width of the shift amount.
REQ-003 Parameter KX_BITS, default 4: width of the kernel-X tap count.
REQ-004 Parameter TILE_BITS, default 8: width of the tile count.
REQ-005 clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a sweep; ignored unless idle.
REQ-007 mode  in  3  network mode; a sweep runs only when mode==MODE_CNN.
REQ-008 cfg_kx  in  KX_BITS  kernel taps per tile, legal 1..15.
REQ-009 cfg_shift  in  MAXIMUM_DILATION_BITS  serial elements shifted per tap, legal 1..N_DIM_ARRAY.
REQ-010 cfg_tiles  in  TILE_BITS  tiles per sweep, legal 1..255.
REQ-011 mem_valid  in  1  activation memory has parallel/serial data for this cycle.
REQ-012 array_ready  in  1  MAC array accepts a tap this cycle.
REQ-013 clear  out  1  buffer clear; loading_in_parallel  out  1  parallel-load strobe.
REQ-014 enable  out  1  serial-shift enable; shift_input_buffer  out  MAXIMUM_DILATION_BITS  shift amount.
REQ-015 mac_valid  out  1  buffer output is valid for the array; busy  out  1; done  out  1  one-cycle end-of-sweep pulse.

Function
REQ-016 FSM states: IDLE, CLEAR, LOAD, LOAD_WAIT, TAP, DONE.
REQ-017 IDLE->CLEAR on start with mode==MODE_CNN; start with any other mode produces a done pulse on the next cycle and no other output activity.
REQ-018 cfg_kx, cfg_shift and cfg_tiles are latched on accepted start; changes mid-sweep have no effect.
REQ-019 CLEAR asserts clear for exactly 1 cycle, then moves to LOAD.
REQ-020 LOAD waits for mem_valid; on mem_valid it asserts loading_in_parallel for 1 cycle and moves to LOAD_WAIT.
REQ-021 LOAD_WAIT lasts exactly 1 cycle, covering the buffer's registered load; all strobes are low during it.
REQ-022 TAP: mac_valid=1; when array_ready&&mem_valid, the tap is consumed and the tap counter increments.
REQ-023 On a consumed tap that is not the last of the tile, enable=1 and shift_input_buffer=latched cfg_shift in the same cycle.
REQ-024 On the last tap (count==cfg_kx-1) no shift is issued; if tiles remain, go to LOAD; otherwise go to DONE.
REQ-025 TAP with !array_ready or !mem_valid holds all counters; enable=0, and mac_valid stays 1.
REQ-026 DONE asserts done for 1 cycle and returns to IDLE; busy=1 in every state except IDLE.
REQ-027 shift_input_buffer is 0 whenever enable=0; clear, loading_in_parallel and enable are mutually exclusive.
REQ-028 cfg_kx==1 performs no serial shifts; cfg_shift==0 latched is treated as 1.
REQ-029 Tap counter width is KX_BITS, tile counter width is TILE_BITS; neither wraps within a legal sweep.

Reset
REQ-030 Reset forces IDLE, zeroes all counters and drives every output to 0; assertion mid-sweep aborts the sweep and produces no done pulse.

Configuration
REQ-031 Macro INPUT_BUFFER_SEQ_STRIDE_EN adds input cfg_stride (1 bit) and outputs enable_strided_conv (1) and cr_fifo (2).
REQ-032 With the macro defined and cfg_stride=1: each LOAD issues two parallel loads on consecutive mem_valid cycles, cr_fifo[0]=0 then 1, and enable_strided_conv=1 for the whole sweep.
REQ-033 In the strided case, cr_fifo[1] toggles on each consumed tap and resets to 0 on each new tile.
REQ-034 Without the macro, these ports do not exist and behaviour is exactly as REQ-016..029.

Structure
REQ-035 MODE_CNN/MODE_FC/MODE_EWS, N_DIM_ARRAY and MAXIMUM_DILATION_BITS come from the shared parameters package.
REQ-036 The FSM state enum typedef is defined in the shared parameters package.
REQ-037 The design is a single module with no sub-modules.

Verification
REQ-038 cfg_kx=3, cfg_shift=1, cfg_tiles=1, mem_valid=array_ready=1, start -> clear@t+1, load@t+2, taps@t+4..t+6, enable@t+4,t+5, done@t+7.
REQ-039 cfg_kx=2, cfg_tiles=3 -> exactly 3 loading_in_parallel pulses and 3 enable pulses with shift_input_buffer=cfg_shift, then 1 done.
REQ-040 array_ready low for 5 cycles mid-TAP -> mac_valid held high, enable=0, tap count unchanged, total enable pulses unchanged.
REQ-041 start with mode==MODE_FC -> done on the next cycle; clear, load and enable never asserted.
REQ-042 Reset asserted in TAP -> all outputs 0 immediately; a following start runs a complete sweep.
REQ-043 STRIDE_EN build, cfg_stride=1, cfg_kx=2 -> two loads per tile with cr_fifo[0]=0 then 1; cr_fifo[1]=0,1 across the two taps.
